axi_mem_arbiter: RTL and testbench

//  2:1 AXI4 arbiter sharing the single-outstanding simple-SoC SRAM slave between IFU (m0, read-only) and LSU (m1, read/write).

---
 rtl/axi_mem_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_axi_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_arbiter.sv
// axi_mem_arbiter: 2:1 single-outstanding AXI4 arbiter, IFU (m0, read) and LSU (m1, read/write) onto one SRAM slave.
// Define ARB_RR_EN for round-robin between m0 and m1; default is fixed priority m1 > m0.
module axi_mem_arbiter #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int IDW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_arvalid,
  input  logic [AW-1:0]     m0_araddr,
  input  logic [IDW-1:0]    m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  output logic              m0_arready,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic [IDW-1:0]    m0_rid,
  input  logic              m0_rready,
  input  logic              m1_arvalid,
  input  logic [AW-1:0]     m1_araddr,
  input  logic [IDW-1:0]    m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  output logic              m1_arready,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic [IDW-1:0]    m1_rid,
  input  logic              m1_rready,
  input  logic              m1_awvalid,
  input  logic [AW-1:0]     m1_awaddr,
  input  logic [IDW-1:0]    m1_awid,
  input  logic [7:0]        m1_awlen,
  input  logic [2:0]        m1_awsize,
  input  logic [1:0]        m1_awburst,
  output logic              m1_awready,
  input  logic              m1_wvalid,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_wstrb,
  input  logic              m1_wlast,
  output logic              m1_wready,
  output logic              m1_bvalid,
  output logic [1:0]        m1_bresp,
  output logic [IDW-1:0]    m1_bid,
  input  logic              m1_bready,
  output logic              s_arvalid,
  output logic [AW-1:0]     s_araddr,
  output logic [IDW-1:0]    s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  input  logic              s_arready,
  input  logic              s_rvalid,
  input  logic [DW-1:0]     s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic [IDW-1:0]    s_rid,
  output logic              s_rready,
  output logic              s_awvalid,
  output logic [AW-1:0]     s_awaddr,
  output logic [IDW-1:0]    s_awid,
  output logic [7:0]        s_awlen,
  output logic [2:0]        s_awsize,
  output logic [1:0]        s_awburst,
  input  logic              s_awready,
  output logic              s_wvalid,
  output logic [DW-1:0]     s_wdata,
  output logic [DW/8-1:0]   s_wstrb,
  output logic              s_wlast,
  input  logic              s_wready,
  input  logic              s_bvalid,
  input  logic [1:0]        s_bresp,
  input  logic [IDW-1:0]    s_bid,
  output logic              s_bready
);
  typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WADDR, S_WRESP} state_t;
  state_t r_state, w_state_nx;
  logic r_grant, r_aw_done, r_w_done;
  logic w_grant_nx, w_aw_done_nx, w_w_done_nx;
  logic w_ra, w_rd, w_wa, w_wr, w_r0o, w_r1o;
  logic w_r0, w_w1, w_m1_req, w_pick_m1, w_aw_ok, w_w_ok;
  assign w_ra = r_state == S_RADDR;
  assign w_rd = r_state == S_RDATA;
  assign w_wa = r_state == S_WADDR;
  assign w_wr = r_state == S_WRESP;
  assign w_r0 = m0_arvalid;
  assign w_w1 = m1_awvalid & m1_wvalid;
  assign w_m1_req = m1_arvalid | w_w1;
`ifdef ARB_RR_EN
  logic r_rr_last;
  assign w_pick_m1 = w_m1_req & (~w_r0 | ~r_rr_last);
`else
  assign w_pick_m1 = w_m1_req;
`endif
  assign w_aw_ok = r_aw_done | (s_awvalid & s_awready);
  assign w_w_ok  = r_w_done | (s_wvalid & s_wready);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_grant   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
`ifdef ARB_RR_EN
      r_rr_last <= 1'b1;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_grant   <= w_grant_nx;
      r_aw_done <= w_aw_done_nx;
      r_w_done  <= w_w_done_nx;
`ifdef ARB_RR_EN
      if (r_state == S_IDLE && (w_r0 | w_m1_req)) r_rr_last <= w_pick_m1;
`endif
    end
  end
  always_comb begin
    w_state_nx   = r_state;
    w_grant_nx   = r_grant;
    w_aw_done_nx = r_aw_done;
    w_w_done_nx  = r_w_done;
    case (r_state)
      S_IDLE: if (w_r0 | w_m1_req) begin
        w_grant_nx = w_pick_m1;
        w_state_nx = (w_pick_m1 & w_w1) ? S_WADDR : S_RADDR;
      end
      S_RADDR: if (s_arvalid & s_arready) w_state_nx = S_RDATA;
      S_RDATA: if (s_rvalid & s_rready & s_rlast) w_state_nx = S_IDLE;
      S_WADDR: begin
        w_state_nx   = (w_aw_ok & w_w_ok) ? S_WRESP : S_WADDR;
        w_aw_done_nx = w_aw_ok & ~w_w_ok;
        w_w_done_nx  = w_w_ok & ~w_aw_ok;
      end
      S_WRESP: if (s_bvalid & s_bready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end
  // Read address: forward granted master, ready only back to the owner
  assign s_arvalid  = w_ra & (r_grant ? m1_arvalid : m0_arvalid);
  assign s_araddr   = w_ra ? (r_grant ? m1_araddr : m0_araddr) : '0;
  assign s_arid     = w_ra ? (r_grant ? m1_arid : m0_arid) : '0;
  assign s_arlen    = w_ra ? (r_grant ? m1_arlen : m0_arlen) : '0;
  assign s_arsize   = w_ra ? (r_grant ? m1_arsize : m0_arsize) : '0;
  assign s_arburst  = w_ra ? (r_grant ? m1_arburst : m0_arburst) : '0;
  assign m0_arready = w_ra & ~r_grant & s_arready;
  assign m1_arready = w_ra & r_grant & s_arready;
  assign w_r0o = w_rd & ~r_grant;
  assign w_r1o = w_rd & r_grant;
  assign m0_rvalid = w_r0o & s_rvalid;
  assign m0_rdata  = w_r0o ? s_rdata : '0;
  assign m0_rresp  = w_r0o ? s_rresp : '0;
  assign m0_rlast  = w_r0o & s_rlast;
  assign m0_rid    = w_r0o ? s_rid : '0;
  assign m1_rvalid = w_r1o & s_rvalid;
  assign m1_rdata  = w_r1o ? s_rdata : '0;
  assign m1_rresp  = w_r1o ? s_rresp : '0;
  assign m1_rlast  = w_r1o & s_rlast;
  assign m1_rid    = w_r1o ? s_rid : '0;
  assign s_rready  = w_rd & (r_grant ? m1_rready : m0_rready);
  // Write channels are masked once their handshake has happened
  assign s_awvalid  = w_wa & ~r_aw_done & m1_awvalid;
  assign s_awaddr   = w_wa ? m1_awaddr : '0;
  assign s_awid     = w_wa ? m1_awid : '0;
  assign s_awlen    = w_wa ? m1_awlen : '0;
  assign s_awsize   = w_wa ? m1_awsize : '0;
  assign s_awburst  = w_wa ? m1_awburst : '0;
  assign m1_awready = w_wa & ~r_aw_done & s_awready;
  assign s_wvalid   = w_wa & ~r_w_done & m1_wvalid;
  assign s_wdata    = w_wa ? m1_wdata : '0;
  assign s_wstrb    = w_wa ? m1_wstrb : '0;
  assign s_wlast    = w_wa & m1_wlast;
  assign m1_wready  = w_wa & ~r_w_done & s_wready;
  assign m1_bvalid  = w_wr & s_bvalid;
  assign m1_bresp   = w_wr ? s_bresp : '0;
  assign m1_bid     = w_wr ? s_bid : '0;
  assign s_bready   = w_wr & m1_bready;
endmodule

// File: tb/tb_axi_mem_arbiter.sv
// tb_axi_mem_arbiter: directed self-checking bench for axi_mem_arbiter (fixed priority, or round-robin with ARB_RR_EN).
module tb_axi_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic m0_arvalid, m0_arready, m0_rvalid, m0_rlast, m0_rready;
  logic [31:0] m0_araddr, m0_rdata;
  logic [3:0] m0_arid, m0_rid;
  logic [7:0] m0_arlen;
  logic [2:0] m0_arsize;
  logic [1:0] m0_arburst, m0_rresp;
  logic m1_arvalid, m1_arready, m1_rvalid, m1_rlast, m1_rready;
  logic [31:0] m1_araddr, m1_rdata;
  logic [3:0] m1_arid, m1_rid;
  logic [7:0] m1_arlen;
  logic [2:0] m1_arsize;
  logic [1:0] m1_arburst, m1_rresp;
  logic m1_awvalid, m1_awready, m1_wvalid, m1_wlast, m1_wready, m1_bvalid, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0] m1_awid, m1_wstrb, m1_bid;
  logic [7:0] m1_awlen;
  logic [2:0] m1_awsize;
  logic [1:0] m1_awburst, m1_bresp;
  logic s_arvalid, s_arready, s_rvalid, s_rlast, s_rready;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0] s_arid, s_rid;
  logic [7:0] s_arlen;
  logic [2:0] s_arsize;
  logic [1:0] s_arburst, s_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wlast, s_wready, s_bvalid, s_bready;
  logic [31:0] s_awaddr, s_wdata;
  logic [3:0] s_awid, s_wstrb, s_bid;
  logic [7:0] s_awlen;
  logic [2:0] s_awsize;
  logic [1:0] s_awburst, s_bresp;
  int n_run = 0, n_fail = 0, aw_hs = 0, w_hs = 0;

  axi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rid(m0_rid), .m0_rready(m0_rready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rid(m1_rid), .m1_rready(m1_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awid(m1_awid), .m1_awlen(m1_awlen),
    .m1_awsize(m1_awsize), .m1_awburst(m1_awburst), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wlast(m1_wlast),
    .m1_wready(m1_wready), .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bid(m1_bid),
    .m1_bready(m1_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rid(s_rid), .s_rready(s_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awid(s_awid), .s_awlen(s_awlen),
    .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_wready(s_wready), .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bid(s_bid),
    .s_bready(s_bready)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (s_awvalid && s_awready) aw_hs++;
    if (s_wvalid && s_wready) w_hs++;
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    {m0_arvalid, m0_araddr, m0_arid, m0_arlen, m0_arsize, m0_arburst, m0_rready} = '0;
    {m1_arvalid, m1_araddr, m1_arid, m1_arlen, m1_arsize, m1_arburst, m1_rready} = '0;
    {m1_awvalid, m1_awaddr, m1_awid, m1_awlen, m1_awsize, m1_awburst} = '0;
    {m1_wvalid, m1_wdata, m1_wstrb, m1_wlast, m1_bready} = '0;
    {s_arready, s_rvalid, s_rdata, s_rresp, s_rlast, s_rid} = '0;
    {s_awready, s_wready, s_bvalid, s_bresp, s_bid} = '0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    {m0_arvalid, m0_rready, m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_wlast, m1_bready} = '1;
    {s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid} = '1;
    {m0_araddr, m1_araddr, m1_awaddr, m1_wdata, s_rdata} = {5{32'hA5A5_5A5A}};
    repeat (3) nxt;
    n_run++;
    if ({m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid,
         s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready} !== 12'b0) begin
      n_fail++;
      $display("FAIL reset_handshakes: got %b required 0", {m0_arready, m0_rvalid, m1_arready,
               m1_rvalid, m1_awready, m1_wready, m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready});
    end
    n_run++;
    if ({s_araddr, s_awaddr, s_wdata, m0_rdata, m1_rdata} !== 160'b0) begin
      n_fail++;
      $display("FAIL reset_data: got %h required 0", {s_araddr, s_awaddr, s_wdata, m0_rdata, m1_rdata});
    end
    n_run++;
    if (dut.r_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d required 0", dut.r_state);
    end
    clr;
    rst = 1'b1;
    nxt;
  endtask

  task automatic do_m0_read(input logic [31:0] a, input logic [31:0] d);
    m0_arvalid = 1'b1; m0_araddr = a; m0_arid = 4'h3; m0_arlen = 8'd0; m0_arsize = 3'd2;
    m0_arburst = 2'd1; m0_rready = 1'b1; s_arready = 1'b1;
    #1;
    n_run++;
    if ({m0_arready, s_arvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL rd_idle_quiet: got %b required 00", {m0_arready, s_arvalid});
    end
    nxt;
    n_run++;
    if ({s_arvalid, m0_arready, m1_arready, s_araddr} !== {3'b110, a}) begin
      n_fail++;
      $display("FAIL rd_addr: got %h required %h", {s_arvalid, m0_arready, m1_arready, s_araddr}, {3'b110, a});
    end
    nxt;
    m0_arvalid = 1'b0; s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = d; s_rlast = 1'b1; s_rid = 4'h3; s_rresp = 2'd0;
    #1;
    n_run++;
    if ({m0_rvalid, m0_rlast, m1_rvalid, s_rready, m0_rid} !== 8'b1101_0011) begin
      n_fail++;
      $display("FAIL rd_route: got %b required 11010011", {m0_rvalid, m0_rlast, m1_rvalid, s_rready, m0_rid});
    end
    n_run++;
    if (m0_rdata !== d) begin
      n_fail++;
      $display("FAIL rd_data: got %h required %h", m0_rdata, d);
    end
    nxt;
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
    #1;
    n_run++;
    if ({m0_rvalid, s_rready, dut.r_state} !== 5'b0) begin
      n_fail++;
      $display("FAIL rd_release: got %b required 0", {m0_rvalid, s_rready, dut.r_state});
    end
    m0_rready = 1'b0;
  endtask

  task automatic test_m0_read;
    do_m0_read(32'h8000_0000, 32'h0000_0413);
  endtask

  task automatic test_write;
    m1_awvalid = 1'b1; m1_awaddr = 32'h8000_0010; m1_awid = 4'h5; m1_awlen = 8'd0;
    m1_awsize = 3'd2; m1_awburst = 2'd1;
    m1_wvalid = 1'b1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hF; m1_wlast = 1'b1;
    m1_arvalid = 1'b1; m1_araddr = 32'h8000_0020; m1_bready = 1'b1;
    s_wready = 1'b1; s_awready = 1'b0;
    aw_hs = 0; w_hs = 0;
    #1;
    n_run++;
    if ({m1_awready, m1_wready, m1_arready, s_awvalid, s_wvalid} !== 5'b0) begin
      n_fail++;
      $display("FAIL wr_idle_quiet: got %b required 0", {m1_awready, m1_wready, m1_arready, s_awvalid, s_wvalid});
    end
    nxt;
    n_run++;
    if ({s_arvalid, s_awvalid, s_wvalid, m1_awready, m1_wready} !== 5'b01101) begin
      n_fail++;
      $display("FAIL wr_grant_w_over_r: got %b required 01101", {s_arvalid, s_awvalid, s_wvalid, m1_awready, m1_wready});
    end
    n_run++;
    if ({s_awaddr, s_wdata, s_wstrb, s_wlast} !== {32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1}) begin
      n_fail++;
      $display("FAIL wr_fwd: got %h required %h", {s_awaddr, s_wdata, s_wstrb, s_wlast},
               {32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1});
    end
    nxt;
    s_awready = 1'b1; m1_arvalid = 1'b0;
    #1;
    n_run++;
    if ({s_awvalid, s_wvalid, m1_awready, m1_wready} !== 4'b1010) begin
      n_fail++;
      $display("FAIL wr_w_masked: got %b required 1010", {s_awvalid, s_wvalid, m1_awready, m1_wready});
    end
    nxt;
    m1_awvalid = 1'b0; m1_wvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'd0; s_bid = 4'h5;
    #1;
    n_run++;
    if ({m1_bvalid, s_bready, s_awvalid, m1_bresp, m1_bid} !== 9'b110_00_0101) begin
      n_fail++;
      $display("FAIL wr_bresp: got %b required 110000101", {m1_bvalid, s_bready, s_awvalid, m1_bresp, m1_bid});
    end
    nxt;
    s_bvalid = 1'b0; m1_bready = 1'b0;
    #1;
    n_run++;
    if (aw_hs != 1 || w_hs != 1 || dut.r_state !== 3'd0) begin
      n_fail++;
      $display("FAIL wr_single_hs: got aw=%0d w=%0d state=%0d required 1 1 0", aw_hs, w_hs, dut.r_state);
    end
  endtask

  task automatic test_arbitration;
    logic exp_m1;
    rst = 1'b0;
    nxt;
    rst = 1'b1;
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0100; m1_arvalid = 1'b1; m1_araddr = 32'h8000_0200;
    m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b1;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 32'h55;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_RR_EN
      exp_m1 = (i % 2) == 1;
`else
      exp_m1 = 1'b1;
`endif
      nxt;
      n_run++;
      if ({s_araddr, m1_arready, m0_arready} !== {exp_m1 ? 32'h8000_0200 : 32'h8000_0100, exp_m1, ~exp_m1}) begin
        n_fail++;
        $display("FAIL arb_grant%0d: got addr %h m1rdy %b m0rdy %b required m1=%b", i, s_araddr, m1_arready, m0_arready, exp_m1);
      end
      nxt;
      n_run++;
      if ({m1_rvalid, m0_rvalid} !== {exp_m1, ~exp_m1}) begin
        n_fail++;
        $display("FAIL arb_route%0d: got %b required %b", i, {m1_rvalid, m0_rvalid}, {exp_m1, ~exp_m1});
      end
      nxt;
    end
    clr;
    nxt;
  endtask

  task automatic test_reset_mid;
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0008; m0_rready = 1'b1; s_arready = 1'b1;
    nxt;
    nxt;
    m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rlast = 1'b0; s_rdata = 32'h77;
    #1;
    n_run++;
    if ({m0_rvalid, m0_rlast} !== 2'b10) begin
      n_fail++;
      $display("FAIL mid_beat: got %b required 10", {m0_rvalid, m0_rlast});
    end
    nxt;
    s_rvalid = 1'b0;
    #1;
    n_run++;
    if ({m0_rvalid, s_rready} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_stay_rdata: got %b required 01", {m0_rvalid, s_rready});
    end
    rst = 1'b0;
    nxt;
    rst = 1'b1;
    #1;
    n_run++;
    if ({s_rready, dut.r_state} !== 4'b0) begin
      n_fail++;
      $display("FAIL mid_reset_idle: got %b required 0", {s_rready, dut.r_state});
    end
    clr;
    do_m0_read(32'h8000_0004, 32'h1234_5678);
  endtask

  initial begin
    clr;
    rst = 1'b0;
    test_reset;
    test_m0_read;
    test_write;
    test_arbitration;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
